// File: rtl/adc_data_gen_if.sv
// adc_data_gen_if: sample handshake, NCO control and generated ADC clock/data bus.
interface adc_data_gen_if #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_AW    = 2,
   parameter int ACC_WIDTH  = 32
);
   logic                  enable;
   logic [ACC_WIDTH-1:0]  freq_word;
   logic                  in_valid;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_ready;
   logic                  clear_underflow;
   logic                  adc_clk;
   logic [DATA_WIDTH-1:0] adc_data;
   logic                  underflow;
   logic [FIFO_AW:0]      fifo_level;
   modport master (
      output enable, freq_word, in_valid, in_data, clear_underflow,
      input  in_ready, adc_clk, adc_data, underflow, fifo_level
   );
   modport slave (
      input  enable, freq_word, in_valid, in_data, clear_underflow,
      output in_ready, adc_clk, adc_data, underflow, fifo_level
   );
endinterface

// File: rtl/adc_data_gen.sv
// adc_data_gen: regenerates an ADC clock/data pair from a sample FIFO using a phase-accumulator NCO.
module adc_data_gen #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_AW    = 2,
   parameter int ACC_WIDTH  = 32
) (
   input logic clk,
   input logic rst_b,
   adc_data_gen_if.slave bus
);
   localparam int DEPTH = 1 << FIFO_AW;
   logic [ACC_WIDTH-1:0]  acc, acc_n;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [FIFO_AW-1:0]    wr_ptr, rd_ptr;
   logic [FIFO_AW:0]      count;
   logic                  fall, push, pop;
   assign acc_n          = acc + bus.freq_word;
   assign fall           = bus.enable && bus.adc_clk && !acc_n[ACC_WIDTH-1];
   assign push           = bus.in_valid && bus.in_ready;
   assign pop            = fall && count != '0;
   assign bus.in_ready   = !count[FIFO_AW];
   assign bus.fifo_level = count;
   // Data updates only with the falling edge, so it is stable around every rise.
   always_ff @(posedge clk or negedge rst_b)
      if (!rst_b) begin
         acc           <= '0;
         bus.adc_clk   <= 1'b0;
         bus.adc_data  <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         bus.underflow <= 1'b0;
      end else begin
         acc           <= bus.enable ? acc_n : '0;
         bus.adc_clk   <= bus.enable && acc_n[ACC_WIDTH-1];
         if (pop) begin
            bus.adc_data <= mem[rd_ptr];
            rd_ptr       <= rd_ptr + FIFO_AW'(1);
         end
         if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
         count         <= count + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
         bus.underflow <= (fall && count == '0) || (bus.underflow && !bus.clear_underflow);
      end
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= bus.in_data;
endmodule

// File: tb/tb_adc_data_gen.sv
// tb_adc_data_gen: table-driven, directed and randomized checks of adc_data_gen against a queue/phase model.
module tb_adc_data_gen;
   localparam longint unsigned MOD  = 64'h1_0000_0000;
   localparam longint unsigned HALF = 64'h8000_0000;
   logic clk = 1'b0;
   logic rst_b = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;
   adc_data_gen_if b ();
   adc_data_gen dut (.clk(clk), .rst_b(rst_b), .bus(b));
   always #5 clk = ~clk;
   longint unsigned m_phase;
   bit              m_clk, m_uf;
   logic [7:0]      m_data;
   logic [7:0]      m_q[$];
   typedef struct {
      logic       valid;
      logic [7:0] data;
      logic       exp_ready;
      logic [2:0] exp_level;
   } vec_t;
   vec_t tbl[6];
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic model_reset();
      m_phase = 0; m_clk = 0; m_uf = 0; m_data = '0;
      m_q.delete();
   endtask
   task automatic step();
      longint unsigned nxt;
      bit fall, rdy, empty;
      rdy   = m_q.size() < 4;
      empty = m_q.size() == 0;
      nxt   = b.enable ? (m_phase + 64'(b.freq_word)) % MOD : 0;
      fall  = b.enable && m_clk && nxt < HALF;
      if (fall && !empty) m_data = m_q.pop_front();
      m_uf = (fall && empty) || (m_uf && !b.clear_underflow);
      if (b.in_valid && rdy) m_q.push_back(b.in_data);
      m_phase = nxt;
      m_clk   = nxt >= HALF;
      @(posedge clk);
      #1;
      chk("adc_clk", b.adc_clk, m_clk);
      chk("adc_data", b.adc_data, m_data);
      chk("underflow", b.underflow, m_uf);
      chk("fifo_level", b.fifo_level, m_q.size());
      chk("in_ready", b.in_ready, m_q.size() < 4);
   endtask
   task automatic push_idle(input logic [7:0] d);
      b.in_valid = 1; b.in_data = d;
      step();
      b.in_valid = 0;
   endtask
   initial begin
      logic [7:0] seen[4];
      logic [7:0] head;
      int got, rises;
      bit prev_clk;
      logic [7:0] prev_data;
      tbl[0] = '{1, 8'h11, 1, 3'd1};
      tbl[1] = '{1, 8'h22, 1, 3'd2};
      tbl[2] = '{1, 8'h33, 1, 3'd3};
      tbl[3] = '{1, 8'h44, 0, 3'd4};
      tbl[4] = '{1, 8'h55, 0, 3'd4};
      tbl[5] = '{1, 8'h66, 0, 3'd4};
      b.enable = 0; b.freq_word = 32'h4000_0000; b.in_valid = 0; b.in_data = '0; b.clear_underflow = 0;
      model_reset();
      #12;
      chk("rst_adc_clk", b.adc_clk, 0);
      chk("rst_adc_data", b.adc_data, 0);
      chk("rst_underflow", b.underflow, 0);
      chk("rst_level", b.fifo_level, 0);
      chk("rst_ready", b.in_ready, 1);
      @(negedge clk);
      rst_b = 1;
      // Fill past full with the NCO stopped
      foreach (tbl[i]) begin
         b.in_valid = tbl[i].valid; b.in_data = tbl[i].data;
         step();
         chk("tbl_ready", b.in_ready, tbl[i].exp_ready);
         chk("tbl_level", b.fifo_level, tbl[i].exp_level);
      end
      b.in_valid = 0;
      b.enable = 1;
      got = 0;
      for (int i = 0; i < 22; i++) begin
         prev_clk = b.adc_clk;
         step();
         if (prev_clk && !b.adc_clk && got < 4) seen[got++] = b.adc_data;
      end
      chk("fall_count", got, 4);
      chk("seq0", seen[0], 8'h11);
      chk("seq1", seen[1], 8'h22);
      chk("seq2", seen[2], 8'h33);
      chk("seq3", seen[3], 8'h44);
      chk("uf_set", b.underflow, 1);
      chk("uf_hold_data", b.adc_data, 8'h44);
      b.clear_underflow = 1;
      step();
      chk("uf_cleared", b.underflow, 0);
      step();
      chk("uf_set_wins", b.underflow, 1);
      b.clear_underflow = 0;
      b.enable = 0; b.clear_underflow = 1;
      step();
      b.clear_underflow = 0;
      push_idle(8'h5A);
      push_idle(8'hC3);
      b.enable = 1;
      step();
      step();
      chk("pre_drop_clk", b.adc_clk, 1);
      b.enable = 0;
      step();
      chk("drop_clk", b.adc_clk, 0);
      chk("drop_level", b.fifo_level, 2);
      chk("drop_uf", b.underflow, 0);
      head = 8'h5A;
      b.enable = 1;
      step();
      chk("reen_low", b.adc_clk, 0);
      step();
      chk("reen_rise", b.adc_clk, 1);
      step();
      step();
      chk("reen_fall", b.adc_clk, 0);
      chk("reen_pop", b.adc_data, head);
      // Fractional rate with the FIFO kept fed
      b.enable = 0; b.clear_underflow = 1;
      step();
      b.clear_underflow = 0;
      b.freq_word = 32'h3000_0000; b.enable = 1;
      rises = 0;
      for (int i = 0; i < 1600; i++) begin
         prev_clk = b.adc_clk; prev_data = b.adc_data;
         b.in_valid = $urandom_range(0, 3) != 0; b.in_data = 8'($urandom);
         step();
         if (!prev_clk && b.adc_clk) rises++;
         if (b.adc_data != prev_data) chk("data_on_fall", {prev_clk, b.adc_clk}, 2'b10);
      end
      chk("frac_rises_lo", rises >= 299, 1);
      chk("frac_rises_hi", rises <= 301, 1);
      chk("frac_no_uf", b.underflow, 0);
      // Randomized rates, enables, pushes and clears
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) b.freq_word = $urandom_range(32'h0800_0000, 32'h4000_0000);
         if ($urandom_range(0, 49) == 0) b.enable = !b.enable;
         b.in_valid = $urandom_range(0, 1); b.in_data = 8'($urandom);
         b.clear_underflow = $urandom_range(0, 19) == 0;
         step();
      end
      b.in_valid = 0; b.clear_underflow = 0;
      b.enable = 0; b.freq_word = 32'h4000_0000;
      step();
      rst_b = 0;
      #1;
      rst_b = 1;
      model_reset();
      @(negedge clk);
      push_idle(8'h01);
      push_idle(8'h02);
      push_idle(8'h03);
      b.enable = 1;
      step();
      step();
      chk("pre_rst_level", b.fifo_level, 3);
      chk("pre_rst_clk", b.adc_clk, 1);
      #2;
      rst_b = 0;
      #1;
      chk("arst_clk", b.adc_clk, 0);
      chk("arst_data", b.adc_data, 0);
      chk("arst_level", b.fifo_level, 0);
      chk("arst_uf", b.underflow, 0);
      chk("arst_ready", b.in_ready, 1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/adc_data_gen.md
Name: adc_data_gen

Overview:
- Transmit-side counterpart of the ADC input synchroniser: regenerates an ADC-style clock/data pair from samples held in the system clock domain.
- Used for loopback self-test of the baseband input path, and for driving an external DAC or emulated front-end.
- Samples enter through a valid/ready handshake into a small FIFO.
- A phase-accumulator NCO generates adc_clk at a programmable fractional rate.
- adc_data changes only on adc_clk falling edges, so it is stable around every rising edge.

Parameters:
- DATA_WIDTH, 8, sample width.
- FIFO_AW, 2, log2 of FIFO depth (default depth 4).
- ACC_WIDTH, 32, NCO phase accumulator width.

Ports:
- clk  input  1  system clock.
- rst_b  input  1  asynchronous reset, active low.
- enable  input  1  run NCO and output clock; 0 = stopped.
- freq_word  input  ACC_WIDTH  NCO increment; f_adc = f_clk*freq_word/2^ACC_WIDTH.
- in_valid  input  1  sample offered.
- in_data  input  DATA_WIDTH  sample value.
- in_ready  output  1  FIFO can accept a sample (= !full).
- clear_underflow  input  1  clears underflow flag.
- adc_clk  output  1  generated ADC clock (registered).
- adc_data  output  DATA_WIDTH  generated ADC data (registered).
- underflow  output  1  sticky: a falling edge found the FIFO empty.
- fifo_level  output  FIFO_AW+1  current FIFO occupancy, 0..2^FIFO_AW.

Behaviour:
- Reset values: acc=0, adc_clk=0, adc_data=0, FIFO count=0, underflow=0. in_ready=1 and fifo_level=0 after reset.
- freq_word constraint: 0 < freq_word <= 2^(ACC_WIDTH-2), so f_adc <= f_clk/4 and each half period is >=2 clk. Behaviour outside this range is undefined; the bench does not check it.
- NCO, when enable=1, every clk:
  - acc_n = acc + freq_word, mod 2^ACC_WIDTH (wrap-around is intended).
  - acc <= acc_n.
  - adc_clk <= acc_n[MSB].
- fall event = enable && adc_clk==1 && acc_n[MSB]==0.
- On a fall event, in the same cycle that adc_clk goes low:
  - count>0: adc_data <= FIFO head, pop.
  - count==0: adc_data holds its previous value, underflow <= 1.
- Data latency: the popped sample is visible on adc_data in the same cycle adc_clk registers low, and stays stable through the next rising edge and until the following falling edge.
- When enable=0: acc <= 0, adc_clk <= 0, no pops, no underflow. FIFO contents, adc_data and the push side are unaffected.
  - Dropping enable while adc_clk=1 forces adc_clk low without a fall event. The resulting shortened high pulse is accepted.
  - Re-enabling starts from phase 0: the first rising edge comes after ceil(2^(ACC_WIDTH-1)/freq_word) clks.
- FIFO:
  - Synchronous, registered, depth 2^FIFO_AW.
  - Push when in_valid && in_ready; pop on a fall event with count>0.
  - Simultaneous push and pop: count unchanged, order preserved.
  - Push into an empty FIFO in the same cycle as a fall event: the pop decision uses the current count (0), so it records an underflow and the new sample waits for the next fall.
  - Full FIFO: in_ready=0, so no push. A pop in that cycle raises in_ready on the next cycle.
  - Pointers wrap modulo depth. fifo_level equals count.
- underflow: set wins over clear_underflow in the same cycle. Otherwise clear_underflow=1 clears it the next cycle.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronous); FIFO contents are discarded.

Test Plan:
- Basic rate and order: reset; push 0x11,0x22,0x33,0x44 with enable=0 (fifo_level=4, in_ready=0); then freq_word=0x4000_0000 and enable=1.
  -> adc_clk period 4 clk, 2 high / 2 low.
  -> adc_data = 0x11,0x22,0x33,0x44 on successive falls.
  -> Looped into the ADC input synchroniser, sample_data shows the same sequence.
- Full/backpressure: push 6 samples with enable=0.
  -> in_ready=0 after the 4th; 5th and 6th are not accepted; fifo_level=4.
- Underflow: push 0xA5, enable at clk/4.
  -> 1st fall: adc_data=0xA5.
  -> 2nd fall: underflow=1, adc_data stays 0xA5.
  -> clear_underflow pulse clears it; clear coinciding with a 3rd empty fall leaves underflow=1.
- Fractional rate: freq_word=0x3000_0000, FIFO kept fed.
  -> 300±1 adc_clk rising edges in 1600 clk.
  -> No underflow; each adc_data change coincides with adc_clk going low.
- Disable/re-enable: drop enable while adc_clk=1.
  -> adc_clk=0 next cycle; fifo_level unchanged; no underflow.
  -> After re-enable at clk/4, first rise at clk +2 and the next sample pops on the following fall.
- Reset mid-stream: assert rst_b low with fifo_level=3 and adc_clk=1.
  -> adc_clk=0, adc_data=0, fifo_level=0, underflow=0, in_ready=1 immediately, without waiting for a clk edge.
